// File: rtl/ball_mover.sv
// Ball position sequencer: on each frame tick, erase the old ball, consult the collision checkers,
// step the ball one STEP per axis and redraw it, handshaking each paint with the pixel drawer.
module ball_mover #(
  parameter int unsigned X_INIT   = 240,
  parameter int unsigned Y_INIT   = 320,
  parameter int unsigned STEP     = 4,
  parameter int unsigned X_MAX    = 479,
  parameter int unsigned Y_MAX    = 639,
  parameter int unsigned CHK_WAIT = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [1:0] collision,
  input  logic       draw_ack,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] dir,
  output logic       draw_req,
  output logic       erase,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StCheck,
    StMove,
    StDraw
  } state_e;

  localparam logic [2:0]  ChkLast = 3'(CHK_WAIT - 1);
  localparam logic [10:0] StepW   = 11'(STEP);
  localparam logic [10:0] XMaxW   = 11'(X_MAX);
  localparam logic [10:0] YMaxW   = 11'(Y_MAX);
  localparam logic [9:0]  XInitW  = 10'(X_INIT);
  localparam logic [9:0]  YInitW  = 10'(Y_INIT);

  state_e     state_q, state_d;
  logic [2:0] chk_cnt_q, chk_cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic       overrun_q, overrun_d;
  logic       chk_done;

  // One axis step with saturation at 0 and at the axis maximum.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic        neg,
                                           input logic [10:0] max_pos);
    logic [10:0] wide;
    logic [9:0]  res;
    wide = {1'b0, pos};
    if (neg) begin
      if (wide < StepW) begin
        res = 10'd0;
      end else begin
        wide = wide - StepW;
        res  = wide[9:0];
      end
    end else begin
      wide = wide + StepW;
      if (wide > max_pos) begin
        res = max_pos[9:0];
      end else begin
        res = wide[9:0];
      end
    end
    return res;
  endfunction

  assign chk_done = (state_q == StCheck) && (chk_cnt_q == ChkLast);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) state_d = StErase;
      end
      StErase: begin
        if (draw_ack) state_d = StCheck;
      end
      StCheck: begin
        if (chk_done) state_d = StMove;
      end
      StMove: begin
        state_d = StDraw;
      end
      StDraw: begin
        if (draw_ack) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the registered state so they are glitch-free per cycle
  always_comb begin
    draw_req = 1'b0;
    erase    = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StErase: begin
        draw_req = 1'b1;
        erase    = 1'b1;
      end
      StCheck: ;
      StMove:  ;
      StDraw:  draw_req = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath next-state: counter, direction, position, overrun flag
  always_comb begin
    chk_cnt_d = 3'd0;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    overrun_d = overrun_q | (frame_tick & (state_q != StIdle));

    if ((state_q == StCheck) && !chk_done) begin
      chk_cnt_d = chk_cnt_q + 3'd1;
    end

    if (chk_done) begin
      if (collision == 2'b10) begin
        dir_d[0] = ~dir_q[0];
      end else if (collision == 2'b11) begin
        dir_d[1] = ~dir_q[1];
      end
    end

    // Direction was committed when CHECK ended, so MOVE uses the new heading.
    if (state_q == StMove) begin
      x_d = step_axis(x_q, dir_q[0], XMaxW);
      y_d = step_axis(y_q, dir_q[1], YMaxW);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chk_cnt_q <= 3'd0;
      dir_q     <= 2'b00;
      x_q       <= XInitW;
      y_q       <= YInitW;
      overrun_q <= 1'b0;
    end else begin
      chk_cnt_q <= chk_cnt_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      overrun_q <= overrun_d;
    end
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign dir     = dir_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ball_mover.sv
// Randomized bench for ball_mover: drives frame/handshake timing and collision codes, and compares
// against a frame-level reference model of ball position, heading and overrun.
module tb_ball_mover;

  localparam int XInit   = 240;
  localparam int YInit   = 320;
  localparam int Step    = 4;
  localparam int XMax    = 479;
  localparam int YMax    = 639;
  localparam int ChkWait = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic [1:0] collision;
  logic       draw_ack;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [1:0] dir;
  logic       draw_req;
  logic       erase;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         mx;
  int         my;
  logic [1:0] mdir;
  bit         movr;

  ball_mover #(
    .X_INIT  (XInit),
    .Y_INIT  (YInit),
    .STEP    (Step),
    .X_MAX   (XMax),
    .Y_MAX   (YMax),
    .CHK_WAIT(ChkWait)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .frame_tick(frame_tick),
    .collision (collision),
    .draw_ack  (draw_ack),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .dir       (dir),
    .draw_req  (draw_req),
    .erase     (erase),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int step_ref(input int v, input bit neg, input int maxv);
    if (neg) return (v < Step) ? 0 : v - Step;
    return (v + Step > maxv) ? maxv : v + Step;
  endfunction

  task automatic check_pos(input string tag);
    check_eq({tag, "_x"}, 32'(ball_x), mx);
    check_eq({tag, "_y"}, 32'(ball_y), my);
    check_eq({tag, "_dir"}, 32'(dir), 32'(mdir));
  endtask

  task automatic model_reset();
    mx   = XInit;
    my   = YInit;
    mdir = 2'b00;
    movr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_pos(tag);
    check_eq({tag, "_req"}, 32'(draw_req), 0);
    check_eq({tag, "_erase"}, 32'(erase), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_ovr"}, 32'(overrun), 0);
  endtask

  // Reset applied mid-cycle; outputs must respond without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    resetn     = 1'b0;
    frame_tick = 1'b0;
    draw_ack   = 1'b0;
    model_reset();
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // One full frame starting from IDLE at a negedge.
  task automatic do_frame(input logic [1:0] col, input int de, input int dd, input int nbusy,
                          input bit tick_done);
    frame_tick = 1'b1;
    draw_ack   = 1'($urandom);
    @(negedge clk);
    frame_tick = 1'b0;
    draw_ack   = 1'b0;
    check_eq("erase_req", 32'(draw_req), 1);
    check_eq("erase_flag", 32'(erase), 1);
    check_eq("erase_busy", 32'(busy), 1);
    check_pos("erase_pos");
    for (int i = 0; i < de; i++) begin
      frame_tick = ((i % 2) == 0) && ((i / 2) < nbusy);
      if (frame_tick) movr = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check_eq("erase_hold", 32'(draw_req), 1);
    end
    check_pos("erase_wait_pos");
    check_eq("erase_ovr", 32'(overrun), 32'(movr));
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack  = 1'($urandom);
    collision = 2'($urandom);
    check_eq("check_req", 32'(draw_req), 0);
    check_eq("check_busy", 32'(busy), 1);
    repeat (ChkWait - 1) begin
      @(negedge clk);
      check_pos("check_pos");
      collision = 2'($urandom);
    end
    collision = col;
    if (col == 2'b10) mdir[0] = ~mdir[0];
    else if (col == 2'b11) mdir[1] = ~mdir[1];
    @(negedge clk);
    collision = 2'($urandom);
    draw_ack  = 1'($urandom);
    check_pos("move_pre");
    check_eq("move_req", 32'(draw_req), 0);
    mx = step_ref(mx, mdir[0], XMax);
    my = step_ref(my, mdir[1], YMax);
    @(negedge clk);
    draw_ack = 1'b0;
    check_eq("draw_req", 32'(draw_req), 1);
    check_eq("draw_erase", 32'(erase), 0);
    check_pos("draw_pos");
    for (int i = 0; i < dd; i++) begin
      @(negedge clk);
      check_eq("draw_hold", 32'(draw_req), 1);
    end
    draw_ack   = 1'b1;
    frame_tick = tick_done;
    if (tick_done) movr = 1'b1;
    @(negedge clk);
    draw_ack   = 1'b0;
    frame_tick = 1'b0;
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_req", 32'(draw_req), 0);
    check_eq("idle_ovr", 32'(overrun), 32'(movr));
    check_pos("idle_pos");
    @(negedge clk);
    check_eq("no_queue", 32'(busy), 0);
  endtask

  task automatic rand_frame(input logic [1:0] col);
    int de;
    int dd;
    int nb;
    de = int'($urandom_range(0, 5));
    dd = int'($urandom_range(0, 3));
    nb = int'($urandom_range(0, (de + 1) / 2));
    do_frame(col, de, dd, nb, $urandom_range(0, 9) == 0);
  endtask

  function automatic logic [1:0] rand_col();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return 2'b00;
    if (r == 14) return 2'b01;
    if (r < 17) return 2'b10;
    return 2'b11;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn     = 1'b1;
    frame_tick = 1'b0;
    draw_ack   = 1'b0;
    collision  = 2'b00;
    #1 resetn  = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Plain move, immediate acks
    do_frame(2'b00, 0, 0, 0, 1'b0);
    check_eq("basic_x", 32'(ball_x), 244);
    check_eq("basic_y", 32'(ball_y), 324);
    check_eq("basic_dir", 32'(dir), 0);

    // X hit reverses X
    async_reset("rst_a");
    do_frame(2'b10, 0, 0, 0, 1'b0);
    check_eq("xhit_dir", 32'(dir), 1);
    check_eq("xhit_x", 32'(ball_x), 236);

    // Y hit twice: heading toggles back
    do_frame(2'b11, 1, 1, 0, 1'b0);
    check_eq("yhit1_dir", 32'(dir), 3);
    check_eq("yhit1_y", 32'(ball_y), 320);
    do_frame(2'b11, 0, 2, 0, 1'b0);
    check_eq("yhit2_dir", 32'(dir), 1);
    check_eq("yhit2_y", 32'(ball_y), 324);

    // Long erase stall with ticks dropped while busy
    check_eq("ovr_clear", 32'(overrun), 0);
    do_frame(2'b00, 50, 0, 2, 1'b0);
    check_eq("ovr_set", 32'(overrun), 1);

    // Tick on the DRAW completion edge is dropped
    async_reset("rst_b");
    do_frame(2'b00, 1, 2, 0, 1'b1);
    check_eq("tick_at_done_ovr", 32'(overrun), 1);

    // Reset in every busy state abandons the frame
    for (int k = 0; k <= 4; k++) begin
      frame_tick = 1'b1;
      collision  = 2'b00;
      @(negedge clk);
      frame_tick = 1'b0;
      draw_ack   = 1'b1;
      repeat (k) @(negedge clk);
      if (k == 4) begin
        check_eq("mid_draw_req", 32'(draw_req), 1);
        check_eq("mid_draw_x", 32'(ball_x), step_ref(mx, mdir[0], XMax));
        check_eq("mid_draw_y", 32'(ball_y), step_ref(my, mdir[1], YMax));
      end
      async_reset("rst_mid");
    end

    // Sweep to the walls to exercise both clamps on X and the max clamp on Y
    for (int i = 0; i < 70; i++) rand_frame(2'b00);
    rand_frame(2'b10);
    for (int i = 0; i < 130; i++) rand_frame(2'b00);
    check_eq("clamp_low_x", 32'(ball_x), 0);
    check_eq("clamp_high_y", 32'(ball_y), YMax);

    for (int i = 0; i < 150; i++) rand_frame(rand_col());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ball_mover.md
BALL_MOVER -- requirements
Module: ball_mover

Interface
REQ-001 Parameter X_INIT, 240, ball X after reset.
REQ-002 Parameter Y_INIT, 320, ball Y after reset.
REQ-003 Parameter STEP, 4, pixels moved per axis per update (1..63).
REQ-004 Parameter X_MAX, 479, largest legal ball X.
REQ-005 Parameter Y_MAX, 639, largest legal ball Y.
REQ-006 Parameter CHK_WAIT, 2, cycles spent in CHECK before collision is sampled (1..7).
REQ-007 clk  in  1  single clock; all state updates on posedge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 frame_tick  in  1  one-cycle pulse requesting one ball update.
REQ-010 collision  in  2  code from the collision/edge checkers: 0x none, 10 X hit, 11 Y hit.
REQ-011 draw_ack  in  1  pixel-drawer done with the current request.
REQ-012 ball_x  out  10  current ball X; also the position presented to the checkers.
REQ-013 ball_y  out  10  current ball Y.
REQ-014 dir  out  2  bit0: 0 = +X, 1 = -X; bit1: 0 = +Y, 1 = -Y.
REQ-015 draw_req  out  1  request to the drawer to paint at ball_x/ball_y.
REQ-016 erase  out  1  qualifies draw_req: 1 = paint background, 0 = paint ball.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 overrun  out  1  sticky: a frame_tick arrived while busy.

Function
REQ-019 States SHALL be IDLE, ERASE, CHECK, MOVE, DRAW, encoded in a registered FSM.
REQ-020 IDLE -> ERASE on the posedge where frame_tick=1; draw_req=1 and erase=1 from the next cycle.
REQ-021 ERASE -> CHECK on the posedge where draw_req=1 and draw_ack=1; draw_req drops in the same edge.
REQ-022 CHECK SHALL last exactly CHK_WAIT cycles (internal counter); collision is sampled on the last CHECK posedge; then -> MOVE.
REQ-023 Direction update on the sampled code: 10 flips dir[0]; 11 flips dir[1]; 00/01 leave dir unchanged.
REQ-024 MOVE lasts one cycle: ball_x/ball_y step by STEP using the already-updated dir; then -> DRAW.
REQ-025 Step arithmetic uses 11-bit intermediates; +step result > MAX clamps to MAX; -step with value < STEP clamps to 0.
REQ-026 DRAW: draw_req=1, erase=0 until draw_ack sampled high; then -> IDLE with draw_req low.
REQ-027 ball_x, ball_y, dir SHALL be stable whenever draw_req=1 and throughout CHECK.
REQ-028 draw_ack while draw_req=0 SHALL be ignored; ack in the same cycle draw_req first rises completes the handshake.
REQ-029 No timeout: ERASE/DRAW wait indefinitely for draw_ack.
REQ-030 frame_tick while busy=1 SHALL be dropped (no queued update) and set overrun=1; overrun clears only on reset.
REQ-031 frame_tick on the same posedge DRAW completes SHALL be treated as busy (dropped, overrun set).
REQ-032 One frame_tick SHALL produce exactly one erase/check/move/draw sequence.

Reset
REQ-033 resetn=0 SHALL immediately force: state IDLE, ball_x=X_INIT, ball_y=Y_INIT, dir=00, draw_req=0, erase=0, busy=0, overrun=0, CHECK counter 0.
REQ-034 Reset asserted mid-sequence (any state) SHALL abandon the sequence with no partial position update.
REQ-035 After resetn rises, first frame_tick is honoured no earlier than the following posedge.

Verification
REQ-036 Reset, tick, ack each request in 1 cycle, collision=00 -> erase at (240,320), draw at (244,324), dir=00, busy low again after DRAW.
REQ-037 Reset, tick, collision=10 during CHECK -> dir=01, ball drawn at (236,324).
REQ-038 Position x=2 with dir[0]=1, collision=00, tick -> ball_x=0 (clamped); x=477 with dir[0]=0 -> ball_x=479.
REQ-039 Hold draw_ack low 50 cycles in ERASE, pulse frame_tick twice -> draw_req held, position unchanged, overrun=1, only one move after ack.
REQ-040 Assert resetn=0 during DRAW after a move to (244,324) -> outputs return to (240,320), dir=00, draw_req=0 asynchronously.
REQ-041 Collision=11 with dir=00 sampled, then next tick collision=11 again -> dir 10 then 00, y 316 then 320 (relative to prior y).
